// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter
// Shares the single read port (port B) of the downsampled frame buffer between
// the host readback path and a streaming reader. Arbitration is round-robin
// with one grant per cycle. Read data comes back in grant order, steered to
// its owner by a tag that travels alongside the BRAM read latency.
//
// Optional feature: define FB_ARB_RANGE_CHECK_EN to reject addresses at or
// above FRAME_SIZE. Such a read is still acked and uses its slot, but the BRAM
// is not enabled. It returns zero data with the owner's err flag set. Without
// the macro, every address goes to the BRAM unchanged and the err outputs are
// tied low.

module fb_read_arbiter #(
    parameter int FRAME_SIZE = 76800,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,

    input  logic              strm_req,
    input  logic [ADDR_W-1:0] strm_addr,
    output logic              strm_ack,
    output logic              strm_rvalid,
    output logic [DATA_W-1:0] strm_rdata,
    output logic              strm_err,

    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout
);

    // Reject configurations where the frame cannot be addressed or the
    // return pipeline depth is unsupported.
    if (FRAME_SIZE > (1 << ADDR_W) || RD_LAT < 1 || RD_LAT > 2) begin : g_cfg_check
        $error("fb_read_arbiter: unsupported FRAME_SIZE/ADDR_W/RD_LAT combination");
    end

    // Records who won the most recent grant. The other requester wins the
    // next tie.
    typedef enum logic {
        LAST_HOST = 1'b0,
        LAST_STRM = 1'b1
    } last_t;

    last_t             last_q;

    logic              grant;
    logic              grant_strm;
    logic [ADDR_W-1:0] grant_addr;
    logic              grant_oor;

    // Tag pipeline: index 0 is loaded at the grant edge, alongside bram_en.
    // Index RD_LAT lines up with the cycle in which bram_dout is valid.
    logic              vld_p  [0:RD_LAT];
    logic              own_p  [0:RD_LAT];
    logic              oor_p  [0:RD_LAT];

    logic              ret_vld;
    logic              ret_strm;
    logic              ret_oor;

    // Return data for a rejected address is forced to zero. Otherwise the
    // BRAM output passes through untouched.
    function automatic logic [DATA_W-1:0] mask_rdata(input logic          zero,
                                                     input logic [DATA_W-1:0] dout);
        return zero ? '0 : dout;
    endfunction

`ifdef FB_ARB_RANGE_CHECK_EN
    // An address is out of range once it reaches FRAME_SIZE.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return a >= ADDR_W'(FRAME_SIZE);
    endfunction
`else
    // Without the range check, every address is forwarded to the BRAM.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a != a);
    endfunction
`endif

    // Combinational grant: a lone requester always wins, and on a tie the
    // requester that did not win last time wins. Both acks are held low
    // while in reset.
    always_comb begin
        host_ack = 1'b0;
        strm_ack = 1'b0;
        if (!areset) begin
            if (host_req && strm_req) begin
                host_ack = (last_q == LAST_STRM);
                strm_ack = (last_q == LAST_HOST);
            end else begin
                host_ack = host_req;
                strm_ack = strm_req;
            end
        end
        grant      = host_ack | strm_ack;
        grant_strm = strm_ack;
        grant_addr = strm_ack ? strm_addr : host_addr;
        grant_oor  = grant && out_of_range(grant_addr);
    end

    // Round-robin pointer: follows the winner and holds when nothing is
    // granted.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            last_q <= LAST_STRM;
        end else if (grant) begin
            last_q <= grant_strm ? LAST_STRM : LAST_HOST;
        end
    end

    // ---- stage p0: BRAM request registered one cycle after the ack ----
    // The address is captured on every grant. The enable is suppressed for
    // rejected addresses, so the BRAM never sees them.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bram_en   <= 1'b0;
            bram_addr <= '0;
        end else begin
            bram_en <= grant && !grant_oor;
            if (grant) begin
                bram_addr <= grant_addr;
            end
        end
    end

    // ---- stages p0..pRD_LAT: tag shift register tracking the BRAM latency ----
    // Reset clears every tag, so reads in flight are dropped.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                vld_p[i] <= 1'b0;
                own_p[i] <= 1'b0;
                oor_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= grant;
            own_p[0] <= grant_strm;
            oor_p[0] <= grant_oor;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                own_p[i] <= own_p[i-1];
                oor_p[i] <= oor_p[i-1];
            end
        end
    end

    // ---- return: decode the tag leaving the pipeline and steer it to its owner ----
    // The non-owner's rdata still shows bram_dout. That requester ignores it
    // because its rvalid is low.
    always_comb begin
        ret_vld     = vld_p[RD_LAT];
        ret_strm    = own_p[RD_LAT];
        ret_oor     = oor_p[RD_LAT];
        host_rvalid = ret_vld && !ret_strm;
        strm_rvalid = ret_vld &&  ret_strm;
        host_rdata  = mask_rdata(host_rvalid && ret_oor, bram_dout);
        strm_rdata  = mask_rdata(strm_rvalid && ret_oor, bram_dout);
`ifdef FB_ARB_RANGE_CHECK_EN
        host_err    = host_rvalid && ret_oor;
        strm_err    = strm_rvalid && ret_oor;
`else
        host_err    = 1'b0;
        strm_err    = 1'b0;
`endif
    end

endmodule

// File: doc/fb_read_arbiter.md
# fb_read_arbiter

Read-port arbiter for the 16-bit × 76800 downsampled frame buffer. It shares the buffer's single 100 MHz read port between the AXI-Lite host readback path and a streaming reader such as a display or DMA scanner. Arbitration is round-robin, one grant per cycle, with in-order tagged return of read data. The block sits between the requesters and port B of the BRAM, in place of a direct address hookup.

## Interface
- FRAME_SIZE, 76800 — number of valid pixel addresses
- ADDR_W, 17 — address width
- DATA_W, 16 — pixel width
- RD_LAT, 1 — BRAM read latency in cycles (1 or 2)

Ports:
- aclk  in  1  100 MHz clock; only clock
- areset  in  1  asynchronous, active-high reset
- host_req  in  1  host read request; held with host_addr until host_ack
- host_addr  in  ADDR_W  host read address
- host_ack  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- host_err  out  1  host read was out of range (with host_rvalid)
- strm_req  in  1  stream read request
- strm_addr  in  ADDR_W  stream read address
- strm_ack  out  1  stream request accepted
- strm_rvalid  out  1  stream read data valid
- strm_rdata  out  DATA_W  stream read data
- strm_err  out  1  stream read was out of range
- bram_en  out  1  BRAM read enable
- bram_addr  out  ADDR_W  BRAM read address
- bram_dout  in  DATA_W  BRAM read data

## Operation
- Arbitration state LAST ∈ {HOST, STRM}. Reset value is STRM, so the host wins the first tie.
- Grant rules:
  - Only host_req high → host_ack.
  - Only strm_req high → strm_ack.
  - Both high → grant the requester ≠ LAST.
  - LAST updates to the granted requester on every grant. With no request, LAST holds.
- Ack is combinational from req and LAST; it does not depend on the address, and at most one ack is high per cycle.
- Requester rules:
  - A requester may keep req high with a new address each cycle it is acked (back-to-back reads).
  - An un-acked requester must hold req and addr stable.
- Request pipeline:
  - On a grant, bram_addr is registered from the winner's address and bram_en is set for one cycle.
  - A tag {valid, owner, oor} enters a shift register RD_LAT deep.
- Return path:
  - When a tag exits with valid=1, the owner's rvalid pulses for one cycle.
  - The owner's rdata = oor ? 0 : bram_dout. Non-owner rdata also shows bram_dout and must be ignored without rvalid.
- Data returns in grant order. There is no reordering and no backpressure on the return path; requesters must always accept.
- Continuous contention alternates grants: H, S, H, S… Each requester gets a guaranteed 50% share, and a single requester alone gets 100%.

## Timing
- Cycle C (req && ack, combinational): the request is accepted at the rising edge that ends cycle C.
- Cycle C+1: bram_en=1, bram_addr = accepted address.
- Cycle C+1+RD_LAT: owner rvalid=1 and rdata valid. Total latency is 1+RD_LAT cycles from ack.
- Reset values (areset high, asynchronous):
  - bram_en=0, bram_addr=0.
  - All rvalid/err = 0, all tags cleared, LAST=STRM.
  - host_ack and strm_ack are forced to 0 while areset is high.
- Reset mid-operation: in-flight reads are discarded, and no rvalid is produced for them after reset deasserts. The first cycle after deassert arbitrates normally.
- Address boundary: the last valid address is FRAME_SIZE-1 (76799). The behaviour for addresses at or above FRAME_SIZE is set under Configuration.

## Configuration
- FB_ARB_RANGE_CHECK_EN defined:
  - An address ≥ FRAME_SIZE is still acked and consumes its slot.
  - For that slot, bram_en stays 0 and the tag sets oor=1.
  - The owner sees rvalid=1, rdata=16'h0000, err=1 in the normal return cycle.
- FB_ARB_RANGE_CHECK_EN undefined:
  - No comparator. The address passes to the BRAM unchanged, and the BRAM's out-of-range behaviour applies.
  - host_err and strm_err are tied to 0.

## Test plan
- Host only, RD_LAT=1, BRAM preloaded with mem[a]=a[15:0]; host reads 0x00010 → host_ack in cycle 0, bram_en/bram_addr=0x00010 in cycle 1, host_rvalid with host_rdata=0x0010 in cycle 2.
- Stream reads back-to-back from 0 to 7 with strm_req held high → 8 consecutive acks, then 8 consecutive strm_rvalid with rdata 0x0000 to 0x0007, in order, with no gaps.
- Both requesters high for 6 cycles after reset → ack order H,S,H,S,H,S, and each rvalid returns only to its own owner with the correct data.
- Range check on, host reads 76799 then 76800 → first return is rdata=mem[76799], err=0; second has bram_en=0 in its slot and returns rdata=0x0000, err=1. With the macro off, err stays 0 throughout.
- areset pulsed one cycle after a stream ack with RD_LAT=2 → no strm_rvalid for that read; all outputs 0 during reset; the next simultaneous request after reset is granted to the host.
- RD_LAT=2 with alternating contention → rvalid arrives 3 cycles after each ack, with no collisions between requesters.
